// File: rtl/vga_pattern_seq_pkg.sv
// Shared types, constants and helpers for the VGA pattern sequencer.
package vga_seq_pkg;

  typedef enum logic {
    S_MANUAL = 1'b0,
    S_AUTO   = 1'b1
  } state_t;

  localparam int DEB_CYCLES_DEF = 1000000;
  localparam int DEB_CNT_W      = $clog2(DEB_CYCLES_DEF + 1);

  // Increment modulo n, wrapping from n-1 back to 0.
  function automatic int wrap_inc(input int v, input int n);
    return (v >= n - 1) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/vga_pattern_seq_if.sv
// Button/frame inputs and pattern-mux outputs of the VGA pattern sequencer.
interface vga_pattern_seq_if #(
  parameter int SEL_W = 2
);
  logic             btn_c;
  logic             btn_u;
  logic             frame_tick;
  logic [SEL_W-1:0] pattern_sel;
  logic             auto_mode;
  logic             pending;
  logic             blank;

  modport master (
    output btn_c, btn_u, frame_tick,
    input  pattern_sel, auto_mode, pending, blank
  );

  modport slave (
    input  btn_c, btn_u, frame_tick,
    output pattern_sel, auto_mode, pending, blank
  );
endinterface

// File: rtl/vga_pattern_seq_btn_debounce.sv
// Two-flop synchroniser, stable-level debouncer and one-clk press pulse.
module btn_debounce
  import vga_seq_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W      = DEB_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);
  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_level_d;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
      // Any sample agreeing with the accepted level restarts the stability count.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;
endmodule

// File: rtl/vga_pattern_seq.sv
// Frame-synchronous pattern selector with manual stepping and auto-advance.
// Optional black frame between patterns when VGA_SEQ_BLANK_EN is defined.
module vga_pattern_seq
  import vga_seq_pkg::*;
#(
  parameter int NUM_PATTERNS = 4,
  parameter int SEL_W        = 2,
  parameter int DEB_CYCLES   = 1000000,
  parameter int AUTO_FRAMES  = 60,
  parameter int FCNT_W       = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  vga_pattern_seq_if.slave    bus
);
  state_t            r_state;
  logic [SEL_W-1:0]  r_target;
  logic [SEL_W-1:0]  r_sel;
  logic              r_auto;
  logic              r_pending;
  logic [FCNT_W-1:0] r_fcnt;

  logic              w_c_press;
  logic              w_u_press;
  logic              w_auto_step;
  logic [SEL_W-1:0]  w_wrap_target;
  logic [SEL_W-1:0]  w_tick_target;
  logic [SEL_W-1:0]  w_press_target;
  logic [SEL_W-1:0]  w_sel_next;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_c (
    .clk(clk), .rst_n(rst_n), .i_btn(bus.btn_c), .o_press(w_c_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_u (
    .clk(clk), .rst_n(rst_n), .i_btn(bus.btn_u), .o_press(w_u_press)
  );

  // The tick is resolved first; a coincident press then steps the post-tick target.
  always_comb begin
    w_wrap_target  = SEL_W'(wrap_inc(int'(r_target), NUM_PATTERNS));
    w_auto_step    = bus.frame_tick && (r_state == S_AUTO) && !r_pending &&
                     (r_fcnt == FCNT_W'(AUTO_FRAMES - 1));
    w_tick_target  = w_auto_step ? w_wrap_target : r_target;
    w_press_target = SEL_W'(wrap_inc(int'(w_tick_target), NUM_PATTERNS));
    w_sel_next     = r_sel;
    if (bus.frame_tick && r_pending) begin
      w_sel_next = r_target;
    end else if (w_auto_step) begin
      w_sel_next = w_wrap_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_MANUAL;
      r_target  <= '0;
      r_sel     <= '0;
      r_auto    <= 1'b0;
      r_pending <= 1'b0;
      r_fcnt    <= '0;
    end else begin
      r_sel    <= w_sel_next;
      r_target <= w_c_press ? w_press_target : w_tick_target;
      if (w_c_press) begin
        r_pending <= 1'b1;
      end else if (bus.frame_tick) begin
        r_pending <= 1'b0;
      end
      case (r_state)
        S_MANUAL: begin
          if (w_u_press) begin
            r_state <= S_AUTO;
            r_auto  <= 1'b1;
            r_fcnt  <= '0;
          end
        end
        S_AUTO: begin
          if (bus.frame_tick) begin
            r_fcnt <= (r_pending || w_auto_step) ? '0 : r_fcnt + 1'b1;
          end
          if (w_u_press) begin
            r_state <= S_MANUAL;
            r_auto  <= 1'b0;
            r_fcnt  <= '0;
          end
        end
      endcase
    end
  end

`ifdef VGA_SEQ_BLANK_EN
  logic r_blank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blank <= 1'b0;
    end else if (bus.frame_tick) begin
      r_blank <= (w_sel_next != r_sel);
    end
  end

  assign bus.blank = r_blank;
`else
  assign bus.blank = 1'b0;
`endif

  assign bus.pattern_sel = r_sel;
  assign bus.auto_mode   = r_auto;
  assign bus.pending     = r_pending;
endmodule

// File: tb/tb_vga_pattern_seq.sv
// Directed testbench for vga_pattern_seq with DEB_CYCLES=4, AUTO_FRAMES=3.
module tb_vga_pattern_seq;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  vga_pattern_seq_if #(.SEL_W(2)) bus ();

  vga_pattern_seq #(
    .NUM_PATTERNS(4),
    .SEL_W(2),
    .DEB_CYCLES(4),
    .AUTO_FRAMES(3),
    .FCNT_W(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef VGA_SEQ_BLANK_EN
  localparam logic BLANK_ON = 1'b1;
`else
  localparam logic BLANK_ON = 1'b0;
`endif

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    bus.btn_c      = 1'b0;
    bus.btn_u      = 1'b0;
    bus.frame_tick = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic frame();
    bus.frame_tick = 1'b1;
    step(1);
    bus.frame_tick = 1'b0;
    step(3);
  endtask

  task automatic press_c();
    bus.btn_c = 1'b1;
    step(10);
    bus.btn_c = 1'b0;
    step(10);
  endtask

  task automatic press_u();
    bus.btn_u = 1'b1;
    step(10);
    bus.btn_u = 1'b0;
    step(10);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({bus.pattern_sel, bus.auto_mode, bus.pending, bus.blank} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got sel=%0d auto=%0b pend=%0b blank=%0b, want all 0",
               bus.pattern_sel, bus.auto_mode, bus.pending, bus.blank);
    end
    for (int i = 0; i < 3; i++) begin
      frame();
      n_checks++;
      if (bus.pattern_sel !== 2'd0) begin
        n_fail++;
        $display("FAIL idle_frame%0d: sel=%0d want 0", i, bus.pattern_sel);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_manual_step();
    do_reset();
    bus.btn_c = 1'b1;
    step(10);
    n_checks++;
    if (bus.pending !== 1'b1 || bus.pattern_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL manual_pending: pend=%0b sel=%0d want pend=1 sel=0", bus.pending, bus.pattern_sel);
    end
    bus.btn_c = 1'b0;
    step(10);
    frame();
    n_checks++;
    if (bus.pattern_sel !== 2'd1 || bus.pending !== 1'b0) begin
      n_fail++;
      $display("FAIL manual_apply: sel=%0d pend=%0b want sel=1 pend=0", bus.pattern_sel, bus.pending);
    end
    $display("test_manual_step done: sel=%0d", bus.pattern_sel);
  endtask

  task automatic test_bounce();
    do_reset();
    bus.btn_c = 1'b1; step(2);
    bus.btn_c = 1'b0; step(2);
    bus.btn_c = 1'b1; step(2);
    bus.btn_c = 1'b0; step(12);
    n_checks++;
    if (bus.pending !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_pending: pend=%0b want 0", bus.pending);
    end
    frame();
    n_checks++;
    if (bus.pattern_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL bounce_sel: sel=%0d want 0", bus.pattern_sel);
    end
    $display("test_bounce done");
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 4; i++) press_c();
    frame();
    n_checks++;
    if (bus.pattern_sel !== 2'd0 || bus.pending !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_four: sel=%0d pend=%0b want sel=0 pend=0", bus.pattern_sel, bus.pending);
    end
    for (int i = 0; i < 3; i++) press_c();
    frame();
    n_checks++;
    if (bus.pattern_sel !== 2'd3) begin
      n_fail++;
      $display("FAIL wrap_three: sel=%0d want 3", bus.pattern_sel);
    end
    $display("test_wrap done: sel=%0d", bus.pattern_sel);
  endtask

  task automatic test_auto();
    logic [1:0] exp_sel [7];
    exp_sel = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
    do_reset();
    press_u();
    n_checks++;
    if (bus.auto_mode !== 1'b1) begin
      n_fail++;
      $display("FAIL auto_enter: auto=%0b want 1", bus.auto_mode);
    end
    for (int i = 0; i < 7; i++) begin
      frame();
      n_checks++;
      if (bus.pattern_sel !== exp_sel[i]) begin
        n_fail++;
        $display("FAIL auto_tick%0d: sel=%0d want %0d", i + 1, bus.pattern_sel, exp_sel[i]);
      end
    end
    press_u();
    n_checks++;
    if (bus.auto_mode !== 1'b0) begin
      n_fail++;
      $display("FAIL auto_exit: auto=%0b want 0", bus.auto_mode);
    end
    for (int i = 0; i < 4; i++) frame();
    n_checks++;
    if (bus.pattern_sel !== 2'd2) begin
      n_fail++;
      $display("FAIL auto_frozen: sel=%0d want 2", bus.pattern_sel);
    end
    $display("test_auto done: sel=%0d", bus.pattern_sel);
  endtask

  task automatic test_same_cycle();
    do_reset();
    bus.btn_c = 1'b1;
    // Press pulse is present during the 8th clk after the raw edge.
    step(7);
    bus.frame_tick = 1'b1;
    step(1);
    bus.frame_tick = 1'b0;
    n_checks++;
    if (bus.pattern_sel !== 2'd0 || bus.pending !== 1'b1 || bus.blank !== 1'b0) begin
      n_fail++;
      $display("FAIL same_tick: sel=%0d pend=%0b blank=%0b want sel=0 pend=1 blank=0",
               bus.pattern_sel, bus.pending, bus.blank);
    end
    bus.btn_c = 1'b0;
    step(10);
    frame();
    n_checks++;
    if (bus.pattern_sel !== 2'd1 || bus.blank !== BLANK_ON) begin
      n_fail++;
      $display("FAIL same_next: sel=%0d blank=%0b want sel=1 blank=%0b",
               bus.pattern_sel, bus.blank, BLANK_ON);
    end
    step(5);
    n_checks++;
    if (bus.blank !== BLANK_ON) begin
      n_fail++;
      $display("FAIL blank_hold: blank=%0b want %0b", bus.blank, BLANK_ON);
    end
    frame();
    n_checks++;
    if (bus.blank !== 1'b0 || bus.pattern_sel !== 2'd1) begin
      n_fail++;
      $display("FAIL blank_clear: blank=%0b sel=%0d want blank=0 sel=1", bus.blank, bus.pattern_sel);
    end
    $display("test_same_cycle done: sel=%0d", bus.pattern_sel);
  endtask

  task automatic test_reset_mid();
    do_reset();
    press_c();
    press_u();
    bus.btn_c = 1'b1;
    step(3);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.pattern_sel, bus.auto_mode, bus.pending, bus.blank} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_mid: sel=%0d auto=%0b pend=%0b want all 0",
               bus.pattern_sel, bus.auto_mode, bus.pending);
    end
    bus.btn_c = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);
    frame();
    n_checks++;
    if (bus.pattern_sel !== 2'd0 || bus.pending !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_request: sel=%0d pend=%0b want 0 0", bus.pattern_sel, bus.pending);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_manual_step();
    test_bounce();
    test_wrap();
    test_auto();
    test_same_cycle();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
